// File: rtl/sa_output_collector.sv
// sa_output_collector: deskews systolic-array column results into rows, requantizes with saturation and buffers them in a FWFT row FIFO.
// Define ROUND_EN for round-half-up before the requant shift; default build truncates toward -inf.
module sa_output_collector #(
    parameter int DATA_WIDTH = 12,
    parameter int ACC_WIDTH  = 24,
    parameter int SA_LENGTH  = 8,
    parameter int S          = 7,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [SA_LENGTH-1:0]         col_valid,
    input  logic signed [ACC_WIDTH-1:0]  col_data [SA_LENGTH],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data [SA_LENGTH],
    output logic                         almost_full,
    output logic                         overflow,
    output logic                         skew_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] AF_LVL = (AW+1)'(FIFO_DEPTH - SA_LENGTH - 2);
    localparam logic signed [ACC_WIDTH:0] QMAX = (ACC_WIDTH+1)'((1 << (DATA_WIDTH-1)) - 1);
    localparam logic signed [ACC_WIDTH:0] QMIN = (ACC_WIDTH+1)'(-(1 << (DATA_WIDTH-1)));
`ifdef ROUND_EN
    localparam logic signed [ACC_WIDTH:0] RND = (ACC_WIDTH+1)'(1 << (S-1));
`endif

    logic [SA_LENGTH-1:0]        al_v;
    logic signed [ACC_WIDTH-1:0] al_d [SA_LENGTH];

    // column j sits SA_LENGTH-j stages so every column of a row lands together
    for (genvar j = 0; j < SA_LENGTH; j++) begin : g_col
        localparam int L = SA_LENGTH - j;
        logic [L-1:0]                sv;
        logic signed [ACC_WIDTH-1:0] sd [L];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sv <= '0;
                for (int k = 0; k < L; k++) sd[k] <= '0;
            end else begin
                sv[0] <= col_valid[j];
                sd[0] <= col_data[j];
                for (int k = 1; k < L; k++) begin
                    sv[k] <= sv[k-1];
                    sd[k] <= sd[k-1];
                end
            end
        end
        assign al_v[j] = sv[L-1];
        assign al_d[j] = sd[L-1];
    end

    logic                        row_v;
    logic signed [ACC_WIDTH-1:0] row_d [SA_LENGTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_v    <= 1'b0;
            skew_err <= 1'b0;
            for (int k = 0; k < SA_LENGTH; k++) row_d[k] <= '0;
        end else begin
            row_v <= &al_v;
            if (|al_v && !(&al_v)) skew_err <= 1'b1;
            for (int k = 0; k < SA_LENGTH; k++) row_d[k] <= al_d[k];
        end
    end

    function automatic logic signed [DATA_WIDTH-1:0] requant(input logic signed [ACC_WIDTH-1:0] a);
        logic signed [ACC_WIDTH:0] t;
        t = (ACC_WIDTH+1)'(a);
`ifdef ROUND_EN
        t = t + RND;
`endif
        t = t >>> S;
        return (t > QMAX) ? QMAX[DATA_WIDTH-1:0] : (t < QMIN) ? QMIN[DATA_WIDTH-1:0] : t[DATA_WIDTH-1:0];
    endfunction

    logic                         q_v;
    logic signed [DATA_WIDTH-1:0] q_d [SA_LENGTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_v <= 1'b0;
            for (int k = 0; k < SA_LENGTH; k++) q_d[k] <= '0;
        end else begin
            q_v <= row_v;
            for (int k = 0; k < SA_LENGTH; k++) q_d[k] <= requant(row_d[k]);
        end
    end

    logic [AW-1:0]                wp, rp;
    logic [AW:0]                  cnt;
    logic signed [DATA_WIDTH-1:0] mem [FIFO_DEPTH][SA_LENGTH];
    logic                         pop, wr;

    // a full FIFO still takes a row when the head leaves on the same edge
    always_comb begin
        pop = out_valid && out_ready;
        wr  = q_v && (cnt != DEPTH || pop);
    end

    always_ff @(posedge clk) begin
        if (wr) for (int k = 0; k < SA_LENGTH; k++) mem[wp][k] <= q_d[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
            if (q_v && !wr) overflow <= 1'b1;
        end
    end

    assign out_valid   = cnt != '0;
    assign almost_full = cnt >= AF_LVL;

    always_comb begin
        for (int k = 0; k < SA_LENGTH; k++) out_data[k] = out_valid ? mem[rp][k] : '0;
    end
endmodule

// File: tb/tb_sa_output_collector.sv
// tb_sa_output_collector: randomized bench; a row schedule drives skewed columns and a queue model predicts the FIFO.
`timescale 1ns/1ps
module tb_sa_output_collector;
    localparam int DW = 12, ACCW = 24, N = 8, S = 7, DEPTH = 16, LAT = N + 2, MAXC = 4096;
    typedef logic [N-1:0][DW-1:0] row_t;

    logic clk = 1'b0, rst_n = 1'b0, out_ready = 1'b0;
    logic [N-1:0] col_valid;
    logic signed [ACCW-1:0] col_data [N];
    logic out_valid, almost_full, overflow, skew_err;
    logic signed [DW-1:0] out_data [N];

    int checks = 0, errors = 0;
    int cyc = 0, m_e;
    bit iss_v [MAXC];
    int iss_late [MAXC];
    int iss_d [MAXC][N];
    int nd [N];
    row_t mq [$];
    bit m_ovf = 0, m_skew = 0;

    sa_output_collector #(.DATA_WIDTH(DW), .ACC_WIDTH(ACCW), .SA_LENGTH(N), .S(S), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .col_valid(col_valid), .col_data(col_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .almost_full(almost_full), .overflow(overflow), .skew_err(skew_err)
    );

    always #5 clk = ~clk;

    function automatic int rq(input int xi);
        int x, v;
        x = xi;
`ifdef ROUND_EN
        x = x + (1 << (S-1));
`endif
        v = (x >= 0) ? x / (1 << S) : -((-x + (1 << S) - 1) / (1 << S));
        return (v > 2047) ? 2047 : (v < -2048) ? -2048 : v;
    endfunction

    function automatic row_t exp_row(input int e);
        row_t r;
        for (int j = 0; j < N; j++) r[j] = DW'(rq(iss_d[e][j]));
        return r;
    endfunction

    // reference: each issued row reaches the FIFO LAT edges after its col0 sample
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf = 0;
            m_skew = 0;
        end else begin
            cyc = cyc + 1;
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            m_e = cyc - LAT;
            if (m_e >= 0 && m_e < MAXC && iss_v[m_e] && iss_late[m_e] < 0) begin
                if (mq.size() < DEPTH) mq.push_back(exp_row(m_e));
                else m_ovf = 1;
            end
            m_e = cyc - N;
            if (m_e >= 0 && m_e < MAXC && iss_v[m_e] && iss_late[m_e] >= 0) m_skew = 1;
        end
    end

    always @(negedge clk) begin
        int n, r;
        n = cyc + 1;
        for (int j = 0; j < N; j++) begin
            col_valid[j] = 1'b0;
            col_data[j] = '0;
            r = n - j;
            if (r >= 0 && r < MAXC && iss_v[r] && iss_late[r] != j) begin
                col_valid[j] = 1'b1;
                col_data[j] = ACCW'(iss_d[r][j]);
            end
            r = n - j - 1;
            if (r >= 0 && r < MAXC && iss_v[r] && iss_late[r] == j) begin
                col_valid[j] = 1'b1;
                col_data[j] = ACCW'(iss_d[r][j]);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog time %0t limit %0d", $time, 400000);
        $fatal(1);
    end

    task automatic clear_sched();
        for (int i = 0; i < MAXC; i++) begin
            iss_v[i] = 0;
            iss_late[i] = -1;
        end
    endtask

    task automatic issue(input int late, output int e);
        e = cyc + 2;
        if (e >= MAXC) begin
            $display("FAIL sched got %0d exp below %0d", e, MAXC);
            $fatal(1);
        end
        for (int j = 0; j < N; j++) iss_d[e][j] = nd[j];
        iss_late[e] = late;
        iss_v[e] = 1;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        out_ready = 1'b0;
        rst_n = 1'b0;
        clear_sched();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic rand_row();
        for (int j = 0; j < N; j++)
            case ($urandom_range(0, 3))
                0: nd[j] = int'($signed(ACCW'($urandom)));
                1: nd[j] = int'($urandom_range(0, 600)) - 300;
                2: nd[j] = ($urandom_range(0, 1) ? 1 : -1) * (2047 * 128 + int'($urandom_range(0, 400)) - 200);
                default: nd[j] = 64 * (int'($urandom_range(0, 40)) - 20) + int'($urandom_range(0, 2)) - 1;
            endcase
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if ({out_valid, almost_full, overflow, skew_err} !== 4'b0) begin
            errors++; $display("FAIL reset_flags got %b exp 0000", {out_valid, almost_full, overflow, skew_err});
        end
        for (int j = 0; j < N; j++) begin
            checks++; if (int'(out_data[j]) !== 0) begin
                errors++; $display("FAIL reset_data[%0d] got %0d exp 0", j, out_data[j]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency();
        int e;
        out_ready = 1'b1;
        for (int j = 0; j < N; j++) nd[j] = j << 14;
        issue(-1, e);
        for (int k = 0; k <= LAT + 3; k++) begin
            wait_to(e + k);
            checks++; if (out_valid !== (k == LAT)) begin
                errors++; $display("FAIL lat_valid edge+%0d got %b exp %b", k, out_valid, k == LAT);
            end
            if (k == LAT)
                for (int j = 0; j < N; j++) begin
                    checks++; if (int'(out_data[j]) !== j * 128) begin
                        errors++; $display("FAIL lat_data[%0d] got %0d exp %0d", j, out_data[j], j * 128);
                    end
                end
        end
    endtask

    task automatic test_requant();
        int e1, e2, x0, x1;
        out_ready = 1'b1;
        for (int j = 0; j < N; j++) nd[j] = 0;
        nd[0] = 300000; nd[1] = -300000;
        issue(-1, e1);
        @(negedge clk);
        nd[0] = 64; nd[1] = -64;
        issue(-1, e2);
`ifdef ROUND_EN
        x0 = 1; x1 = 0;
`else
        x0 = 0; x1 = -1;
`endif
        wait_to(e1 + LAT);
        checks++; if (int'(out_data[0]) !== 2047 || int'(out_data[1]) !== -2048 || out_valid !== 1'b1) begin
            errors++; $display("FAIL sat got %0d,%0d exp 2047,-2048", out_data[0], out_data[1]);
        end
        wait_to(e2 + LAT);
        checks++; if (int'(out_data[0]) !== x0 || int'(out_data[1]) !== x1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL round got %0d,%0d exp %0d,%0d", out_data[0], out_data[1], x0, x1);
        end
        for (int j = 2; j < N; j++) begin
            checks++; if (int'(out_data[j]) !== 0) begin
                errors++; $display("FAIL round_zero[%0d] got %0d exp 0", j, out_data[j]);
            end
        end
    endtask

    task automatic test_random();
        int e;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++; if (out_valid !== (mq.size() > 0)) begin
                errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", cyc, out_valid, mq.size() > 0);
            end
            checks++; if (almost_full !== (mq.size() >= DEPTH - N - 2)) begin
                errors++; $display("FAIL rnd_af cyc %0d got %b exp %b", cyc, almost_full, mq.size() >= DEPTH - N - 2);
            end
            checks++; if ({overflow, skew_err} !== {m_ovf, m_skew}) begin
                errors++; $display("FAIL rnd_flags cyc %0d got %b exp %b", cyc, {overflow, skew_err}, {m_ovf, m_skew});
            end
            if (mq.size() > 0)
                for (int j = 0; j < N; j++) begin
                    checks++; if (out_data[j] !== mq[0][j]) begin
                        errors++; $display("FAIL rnd_data[%0d] cyc %0d got %0d exp %0d", j, cyc, out_data[j], $signed(mq[0][j]));
                    end
                end
            out_ready = ($urandom_range(0, 3) != 0);
            if (!almost_full && $urandom_range(0, 1) == 1) begin
                rand_row();
                issue(-1, e);
            end
        end
    endtask

    task automatic test_fill();
        int e, e0, arr;
        do_reset();
        for (int c = 0; c < 34; c++) begin
            if (c < 20) begin
                for (int j = 0; j < N; j++) nd[j] = c << 14;
                issue(-1, e);
                if (c == 0) e0 = e;
            end
            arr = cyc - e0 - LAT + 1;
            arr = (arr < 0 || c == 0) ? 0 : (arr > 20) ? 20 : arr;
            checks++; if ({out_valid, almost_full, overflow} !== {arr >= 1, arr >= 6, arr >= 17}) begin
                errors++; $display("FAIL fill rows %0d got %b exp %b", arr, {out_valid, almost_full, overflow}, {arr >= 1, arr >= 6, arr >= 17});
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            checks++; if (out_valid !== 1'b1 || int'(out_data[0]) !== k * 128 || int'(out_data[N-1]) !== k * 128) begin
                errors++; $display("FAIL drain row %0d got %b/%0d exp 1/%0d", k, out_valid, out_data[0], k * 128);
            end
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b0) begin
            errors++; $display("FAIL drain_empty got %b exp 0", out_valid);
        end
    endtask

    task automatic test_full_pushpop();
        int e, e0;
        do_reset();
        for (int k = 0; k <= DEPTH; k++) begin
            for (int j = 0; j < N; j++) nd[j] = k << 13;
            issue(-1, e);
            if (k == 0) e0 = e;
            @(negedge clk);
        end
        wait_to(e0 + DEPTH - 1 + LAT);
        out_ready = 1'b1;
        wait_to(e0 + DEPTH + LAT);
        out_ready = 1'b0;
        checks++; if ({out_valid, almost_full, overflow} !== 3'b110) begin
            errors++; $display("FAIL full_pp flags got %b exp 110", {out_valid, almost_full, overflow});
        end
        out_ready = 1'b1;
        for (int k = 1; k <= DEPTH; k++) begin
            checks++; if (out_valid !== 1'b1 || int'(out_data[3]) !== k * 64) begin
                errors++; $display("FAIL full_pp row %0d got %b/%0d exp 1/%0d", k, out_valid, out_data[3], k * 64);
            end
            @(negedge clk);
        end
        checks++; if (out_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++; $display("FAIL full_pp_end got %b%b exp 00", out_valid, overflow);
        end
    endtask

    task automatic test_skew();
        int e, e2;
        do_reset();
        out_ready = 1'b1;
        rand_row();
        issue(3, e);
        wait_to(e + N - 1);
        checks++; if (skew_err !== 1'b0) begin
            errors++; $display("FAIL skew_early got %b exp 0", skew_err);
        end
        wait_to(e + N);
        checks++; if (skew_err !== 1'b1) begin
            errors++; $display("FAIL skew_set got %b exp 1", skew_err);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin
                errors++; $display("FAIL skew_drop cyc %0d got %b exp 0", cyc, out_valid);
            end
        end
        rand_row();
        issue(-1, e2);
        wait_to(e2 + LAT);
        checks++; if (out_valid !== 1'b1 || skew_err !== 1'b1 || overflow !== 1'b0) begin
            errors++; $display("FAIL skew_next got %b%b%b exp 110", out_valid, skew_err, overflow);
        end
        for (int j = 0; j < N; j++) begin
            checks++; if (int'(out_data[j]) !== rq(nd[j])) begin
                errors++; $display("FAIL skew_next_data[%0d] got %0d exp %0d", j, out_data[j], rq(nd[j]));
            end
        end
    endtask

    task automatic test_reset_inflight();
        int e, e1;
        do_reset();
        rand_row();
        issue(-1, e);
        wait_to(e + LAT + 2);
        for (int k = 0; k < 3; k++) begin
            rand_row();
            issue(-1, e);
            if (k == 0) e1 = e;
            @(negedge clk);
        end
        wait_to(e1 + N + 1);
        checks++; if (out_valid !== 1'b1) begin
            errors++; $display("FAIL rst_pre got %b exp 1", out_valid);
        end
        rst_n = 1'b0;
        clear_sched();
        #1;
        checks++; if (out_valid !== 1'b0 || int'(out_data[0]) !== 0) begin
            errors++; $display("FAIL rst_async got %b/%0d exp 0/0", out_valid, out_data[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++; if ({out_valid, almost_full, overflow, skew_err} !== 4'b0) begin
                errors++; $display("FAIL rst_after cyc %0d got %b exp 0000", cyc, {out_valid, almost_full, overflow, skew_err});
            end
        end
    endtask

    initial begin
        clear_sched();
        test_reset();
        test_latency();
        test_requant();
        test_random();
        test_fill();
        test_full_pushpop();
        test_skew();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
